// File: rtl/sd_cmd_pkg.sv
// sd_cmd_pkg: shared encodings for the SD command scheduler.
package sd_cmd_pkg;

  localparam int CMD_W = 38;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_ARM,
    ST_RECV,
    ST_GAP,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_R1   = 2'd1,
    RESP_R2   = 2'd2,
    RESP_R3   = 2'd3
  } resp_type_t;

  typedef enum logic [1:0] {
    STS_OK           = 2'd0,
    STS_CRC_ERR      = 2'd1,
    STS_RESP_TIMEOUT = 2'd2,
    STS_SEND_TIMEOUT = 2'd3
  } status_t;

endpackage

// File: rtl/sd_cmd_scheduler_sat_counter.sv
// sd_sat_counter: clearable, enable-driven up-counter that sticks at all-ones
// instead of wrapping; at_limit is high once count has reached limit.
module sd_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  // Count enabled cycles; clear has priority, saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign at_limit = (count >= limit);

endmodule

// File: rtl/sd_cmd_scheduler.sv
// sd_cmd_scheduler: runs one SD CMD-line transaction at a time (send, arm the
// receiver, timeout, bounded retry) and returns one status/response record.
// Optional build macro SD_CMD_SCHED_STATS_EN adds retry_total / fail_total.
module sd_cmd_scheduler
  import sd_cmd_pkg::*;
#(
  parameter logic [15:0] RESP_TIMEOUT = 16'd40000,
  parameter logic [15:0] SEND_TIMEOUT = 16'd20000,
  parameter int          MAX_RETRY    = 2,
  parameter logic [7:0]  GAP_CYCLES   = 8'd64
) (
  input  logic               ex_clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [5:0]         req_index,
  input  logic [31:0]        req_arg,
  input  logic [1:0]         req_resp_type,
  output logic               send_en,
  output logic [CMD_W-1:0]   send_cmd_content,
  input  logic               sd_sending,
  input  logic               sd_finished,
  output logic               receive_en,
  output logic               R2_response,
  output logic               R3_response,
  input  logic               sd_receive_started,
  input  logic               sd_receive_finished,
  input  logic               crc_response_err,
  input  logic [126:0]       response,
  output logic               done_valid,
  output logic [1:0]         done_status,
  output logic [126:0]       done_response
`ifdef SD_CMD_SCHED_STATS_EN
  ,
  output logic [15:0]        retry_total,
  output logic [15:0]        fail_total
`endif
);

  localparam int              RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0]   MAX_R    = RW'(MAX_RETRY);
  // Limits are "last cycle" values: the counter starts at 0 on the first cycle.
  localparam logic [15:0]     SEND_LIM = SEND_TIMEOUT - 16'd1;
  localparam logic [15:0]     RESP_LIM = RESP_TIMEOUT - 16'd1;
  localparam logic [7:0]      GAP_LIM  = GAP_CYCLES - 8'd1;

  state_t          state;
  resp_type_t      cmd_type;
  status_t         status;
  logic [5:0]      cmd_index;
  logic [31:0]     cmd_arg;
  logic [RW-1:0]   retry_cnt;
  logic            retry_pend;
  logic            to_clr, to_en, to_hit;
  logic [15:0]     to_limit, to_count_unused;
  logic            gap_clr, gap_en, gap_hit;
  logic [7:0]      gap_count_unused;
  logic            can_retry, attempt_fail;
  logic            sending_unused;

  // sd_sending carries no information the scheduler needs beyond sd_finished.
  assign sending_unused = sd_sending;

  // Counter controls and the shared failure condition for ARM/RECV.
  always_comb begin
    to_clr       = (state == ST_LOAD) || ((state == ST_SEND) && sd_finished);
    to_en        = (state == ST_SEND) || (state == ST_ARM);
    to_limit     = (state == ST_SEND) ? SEND_LIM : RESP_LIM;
    gap_clr      = (state != ST_GAP);
    gap_en       = (state == ST_GAP);
    can_retry    = (retry_cnt < MAX_R);
    attempt_fail = ((state == ST_ARM) && !sd_receive_started && to_hit) ||
                   ((state == ST_RECV) && sd_receive_finished && crc_response_err);
  end

  sd_sat_counter #(.WIDTH(16)) u_timeout (
    .clk      (ex_clk),
    .rst      (reset),
    .clr      (to_clr),
    .en       (to_en),
    .limit    (to_limit),
    .count    (to_count_unused),
    .at_limit (to_hit)
  );

  sd_sat_counter #(.WIDTH(8)) u_gap (
    .clk      (ex_clk),
    .rst      (reset),
    .clr      (gap_clr),
    .en       (gap_en),
    .limit    (GAP_LIM),
    .count    (gap_count_unused),
    .at_limit (gap_hit)
  );

  // Transaction FSM with registered outputs.
  always_ff @(posedge ex_clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      req_ready        <= 1'b1;
      send_en          <= 1'b0;
      receive_en       <= 1'b0;
      R2_response      <= 1'b0;
      R3_response      <= 1'b0;
      done_valid       <= 1'b0;
      done_status      <= 2'd0;
      done_response    <= '0;
      send_cmd_content <= '0;
      cmd_index        <= '0;
      cmd_arg          <= '0;
      cmd_type         <= RESP_NONE;
      status           <= STS_OK;
      retry_cnt        <= '0;
      retry_pend       <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            cmd_index <= req_index;
            cmd_arg   <= req_arg;
            cmd_type  <= resp_type_t'(req_resp_type);
            retry_cnt <= '0;
            req_ready <= 1'b0;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          send_cmd_content <= {cmd_index, cmd_arg};
          send_en          <= 1'b1;
          state            <= ST_SEND;
        end
        ST_SEND: begin
          if (sd_finished) begin
            send_en <= 1'b0;
            if (cmd_type == RESP_NONE) begin
              status     <= STS_OK;
              retry_pend <= 1'b0;
              state      <= ST_GAP;
            end else begin
              receive_en  <= 1'b1;
              R2_response <= (cmd_type == RESP_R2);
              R3_response <= (cmd_type == RESP_R3);
              state       <= ST_ARM;
            end
          end else if (to_hit) begin
            // A send that never completes points at a broken link; no retry.
            send_en    <= 1'b0;
            status     <= STS_SEND_TIMEOUT;
            retry_pend <= 1'b0;
            state      <= ST_GAP;
          end
        end
        ST_ARM: begin
          if (sd_receive_started) begin
            state <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (sd_receive_finished) begin
            done_response <= response;
            if (!crc_response_err) begin
              receive_en  <= 1'b0;
              R2_response <= 1'b0;
              R3_response <= 1'b0;
              status      <= STS_OK;
              retry_pend  <= 1'b0;
              state       <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_hit) begin
            state <= retry_pend ? ST_LOAD : ST_DONE;
          end
        end
        ST_DONE: begin
          done_valid  <= 1'b1;
          done_status <= status;
          req_ready   <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // CRC error or response timeout: tear down the receive side and retry if allowed.
      if (attempt_fail) begin
        receive_en  <= 1'b0;
        R2_response <= 1'b0;
        R3_response <= 1'b0;
        status      <= (state == ST_ARM) ? STS_RESP_TIMEOUT : STS_CRC_ERR;
        state       <= ST_GAP;
        if (can_retry) begin
          retry_cnt  <= retry_cnt + RW'(1);
          retry_pend <= 1'b1;
        end else begin
          retry_pend <= 1'b0;
        end
      end
    end
  end

`ifdef SD_CMD_SCHED_STATS_EN
  // Saturating event counters for re-issues and failed completions.
  always_ff @(posedge ex_clk) begin
    if (reset) begin
      retry_total <= '0;
      fail_total  <= '0;
    end else begin
      if (attempt_fail && can_retry && (retry_total != 16'hFFFF)) begin
        retry_total <= retry_total + 16'd1;
      end
      if ((state == ST_DONE) && (status != STS_OK) && (fail_total != 16'hFFFF)) begin
        fail_total <= fail_total + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/sd_cmd_scheduler.md
Name: sd_cmd_scheduler

Overview:
Sequences one SD command transaction at a time on the shared CMD line. It accepts a command request from the SD FSM, drives sd_send, then arms sd_receive with the correct response format. It applies the response timeout and a bounded retry policy, and returns a single status and response record. It sits between sd_fsm and the sd_send/sd_receive pair and runs on ex_clk; the send/receive blocks do their own sd_clk-domain handling.

Parameters:
RESP_TIMEOUT, 16'd40000, ex_clk cycles allowed from receive_en assertion to sd_receive_started.
SEND_TIMEOUT, 16'd20000, ex_clk cycles allowed from send_en assertion to sd_finished.
MAX_RETRY, 2, re-issues after CRC error or response timeout (0 = no retry).
GAP_CYCLES, 8'd64, idle ex_clk cycles enforced after each attempt (Ncc spacing).

Ports:
ex_clk  in  1  system clock; sole clock.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  command request.
req_ready  out  1  scheduler idle; a request is accepted when req_valid & req_ready.
req_index  in  6  command index.
req_arg  in  32  command argument.
req_resp_type  in  2  0=none, 1=48-bit (R1/R6/R7), 2=R2, 3=R3.
send_en  out  1  to sd_send.
send_cmd_content  out  38  {index, arg}, held stable for the whole attempt.
sd_sending  in  1  from sd_send.
sd_finished  in  1  from sd_send, pulse.
receive_en  out  1  to sd_receive.
R2_response  out  1  to sd_receive.
R3_response  out  1  to sd_receive.
sd_receive_started  in  1  start bit seen.
sd_receive_finished  in  1  response complete, pulse.
crc_response_err  in  1  qualified only by sd_receive_finished.
response  in  127  from sd_receive.
done_valid  out  1  one-cycle completion pulse.
done_status  out  2  0=OK, 1=CRC_ERR, 2=RESP_TIMEOUT, 3=SEND_TIMEOUT.
done_response  out  127  captured response; held until the next capture.

Behaviour:
- Reset (synchronous, active-high):
  - State is IDLE.
  - req_ready=1.
  - send_en, receive_en, R2_response, R3_response, done_valid = 0.
  - done_status=0, done_response=0, send_cmd_content=0.
  - Counters are cleared.
  - Reset asserted in any state aborts the transaction with no done_valid pulse.
- IDLE:
  - req_ready=1.
  - On accept, latch index/arg/resp_type and set retry_cnt=0.
  - Next state LOAD; req_ready drops the next cycle.
- LOAD: drive send_cmd_content; clear the timeout counter; next state SEND.
- SEND:
  - send_en=1 until sd_finished; the timeout counter increments each cycle.
  - On sd_finished, deassert send_en the next cycle.
  - If resp_type=0, go to GAP with status OK.
  - Otherwise go to ARM, with R2_response/R3_response set from resp_type.
  - If the counter reaches SEND_TIMEOUT before sd_finished, go to GAP with status SEND_TIMEOUT; this status is not retried.
- ARM:
  - receive_en=1, with R2/R3 held.
  - If sd_receive_started arrives before the counter reaches RESP_TIMEOUT, go to RECV.
  - Otherwise the attempt fails with RESP_TIMEOUT.
- RECV:
  - receive_en held; no timeout applies.
  - On sd_receive_finished, capture response into done_response.
  - Status is CRC_ERR if crc_response_err is set that same cycle, else OK.
- Failure handling (CRC_ERR or RESP_TIMEOUT):
  - If retry_cnt < MAX_RETRY, increment retry_cnt and go to GAP, then LOAD.
  - Otherwise go to GAP, then DONE.
- GAP:
  - All enables are 0.
  - Wait GAP_CYCLES, then go to LOAD (retry) or DONE.
- DONE: done_valid=1 for exactly one cycle; return to IDLE.
- Latency: req accept to send_en is 2 cycles; sd_receive_finished to done_valid is GAP_CYCLES+2 cycles.
- Simultaneous events:
  - sd_receive_started and timeout expiry in the same cycle: started wins.
  - sd_finished while in ARM/RECV: ignored.
  - req_valid while busy: not accepted.
- Counter widths: 16-bit timeout counter that saturates and does not wrap; 8-bit gap counter; retry counter is $clog2(MAX_RETRY+1) bits.

Optional Feature:
SD_CMD_SCHED_STATS_EN
- Defined: adds outputs retry_total (16) and fail_total (16).
  - retry_total increments on each re-issue.
  - fail_total increments on each done_valid with status≠OK.
  - Both saturate at 16'hFFFF and are cleared by reset.
- Undefined: neither the ports nor the counters exist; behaviour is otherwise identical.

Decomposition:
- Package sd_cmd_pkg holds:
  - the state encoding (IDLE, LOAD, SEND, ARM, RECV, GAP, DONE);
  - resp_type codes;
  - done_status codes;
  - the send_cmd_content width constant (38).
- One sub-module, sd_sat_counter: a clearable, saturating, enable-driven up-counter with a compare-to-limit flag. It is used for the timeout and gap counters.

Test Plan:
- CMD0 (index 0, arg 0, resp_type 0); sd_finished 50 cycles after send_en:
  - send_cmd_content=38'h0, receive_en never asserted;
  - done_valid with status 0 exactly GAP_CYCLES+2 cycles after sd_finished.
- CMD2 (resp_type 2):
  - R2_response=1, R3_response=0 during ARM/RECV;
  - response=127'h5A… captured, done_status 0.
- CMD8 (arg 32'h1AA); crc_response_err on the first two finishes, clean on the third (MAX_RETRY=2):
  - three send_en assertions, done_status 0 (with STATS: retry_total=2);
  - with crc_err on all three: done_status 1.
- ACMD41 (resp_type 3); sd_receive_started never arrives:
  - three ARM phases of RESP_TIMEOUT cycles each, then done_status 2.
- sd_finished withheld: done_status 3 after SEND_TIMEOUT cycles, with no retry.
- reset pulsed mid-RECV:
  - all outputs at their reset values the next cycle;
  - no done_valid;
  - a new request is accepted immediately afterwards.
